ntt_intt_ext_obi_demux: RTL and testbench

Parametrised 1-to-NSLAVE OBI demultiplexer. It sits between the X-HEEP external slave bus master port and the NTT/INTT accelerator slave ports. Each request is routed to the port selected by a configurable address-rule table, and read responses are returned strictly in order. It tracks up to MAX_TRANS outstanding transactions, stalls any target switch until the previous target has drained, and can optionally answer unmapped addresses itself.

---
 rtl/ntt_intt_ext_xbar_pkg.sv | 60 ++++++
 rtl/ntt_intt_ext_addr_decode.sv | 35 +++
 rtl/ntt_intt_ext_obi_demux.sv | 154 +++++++++++++++
 tb/tb_ntt_intt_ext_obi_demux.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_intt_ext_xbar_pkg.sv
// ============================================================================
// Module      : ntt_intt_ext_xbar_pkg
// Description : Shared OBI types, NTT/INTT address map and helpers for the
//               external-slave demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_intt_ext_xbar_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Start inclusive, end exclusive.
    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam int unsigned NSLAVE_DEFAULT = 2;

    localparam int unsigned NTT_IDX    = 0;
    localparam logic [31:0] NTT_START  = 32'hF000_0000;
    localparam logic [31:0] NTT_SIZE   = 32'h0020_0000;
    localparam logic [31:0] NTT_END    = NTT_START + NTT_SIZE;

    localparam int unsigned INTT_IDX   = 1;
    localparam logic [31:0] INTT_START = 32'hF020_0000;
    localparam logic [31:0] INTT_SIZE  = 32'h0020_0000;
    localparam logic [31:0] INTT_END   = INTT_START + INTT_SIZE;

    // Concatenation order places the INTT rule at index INTT_IDX (MSB slot).
    localparam addr_map_rule_t [NSLAVE_DEFAULT-1:0] DEFAULT_ADDR_RULES = {
        addr_map_rule_t'{start_addr: INTT_START, end_addr: INTT_END},
        addr_map_rule_t'{start_addr: NTT_START,  end_addr: NTT_END}
    };

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    // Port-select width must also encode the virtual "unmapped" target NSLAVE.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_intt_ext_addr_decode.sv
// ============================================================================
// Module      : ntt_intt_ext_addr_decode
// Description : Combinational address decoder; lowest matching rule wins,
//               no match yields target NSLAVE and the unmapped flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_intt_ext_addr_decode
    import ntt_intt_ext_xbar_pkg::*;
#(
    parameter int unsigned                    NSLAVE     = NSLAVE_DEFAULT,
    parameter int unsigned                    SELW       = sel_width(NSLAVE),
    parameter addr_map_rule_t [NSLAVE-1:0]    ADDR_RULES = DEFAULT_ADDR_RULES
) (
    input  logic [31:0]     i_addr,
    output logic [SELW-1:0] o_target,
    output logic            o_unmapped
);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        o_target   = SELW'(NSLAVE);
        o_unmapped = 1'b1;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if ((i_addr >= ADDR_RULES[i].start_addr) && (i_addr < ADDR_RULES[i].end_addr)) begin
                o_target   = SELW'(i);
                o_unmapped = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ntt_intt_ext_obi_demux.sv
// ============================================================================
// Module      : ntt_intt_ext_obi_demux
// Description : 1-to-NSLAVE in-order OBI demultiplexer for the NTT/INTT slaves.
//               Define NTT_INTT_EXT_ERR_RESP_EN to answer unmapped accesses
//               locally with ERR_RDATA instead of routing them to port 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_intt_ext_obi_demux
    import ntt_intt_ext_xbar_pkg::*;
#(
    parameter int unsigned                 NSLAVE     = NSLAVE_DEFAULT,
    parameter int unsigned                 MAX_TRANS  = 4,
    parameter addr_map_rule_t [NSLAVE-1:0] ADDR_RULES = DEFAULT_ADDR_RULES
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  obi_req_t                       master_req_i,
    output obi_resp_t                      master_resp_o,
    output obi_req_t                       slave_req_o  [NSLAVE],
    input  obi_resp_t                      slave_resp_i [NSLAVE],
    output logic [$clog2(MAX_TRANS+1)-1:0] outstanding_o,
    output logic                           unmapped_o
);

    localparam int unsigned     SELW        = sel_width(NSLAVE);
    localparam int unsigned     CNTW        = $clog2(MAX_TRANS + 1);
    localparam logic [SELW-1:0] C_UNMAP_SEL = SELW'(NSLAVE);
    localparam logic [CNTW-1:0] C_MAX_TRANS = CNTW'(MAX_TRANS);

    logic [CNTW-1:0] r_cnt;
    logic [SELW-1:0] r_sel;
    logic            r_err_rvalid;

    logic [SELW-1:0] w_dec_target;
    logic [SELW-1:0] w_target;
    logic            w_unmapped;
    logic            w_allowed;
    logic            w_gnt;
    logic            w_hs;
    logic            w_slv_rvalid;
    logic [31:0]     w_slv_rdata;
    logic            w_rsp;

    ntt_intt_ext_addr_decode #(
        .NSLAVE     (NSLAVE),
        .SELW       (SELW),
        .ADDR_RULES (ADDR_RULES)
    ) u_addr_decode (
        .i_addr     (master_req_i.addr),
        .o_target   (w_dec_target),
        .o_unmapped (w_unmapped)
    );

`ifdef NTT_INTT_EXT_ERR_RESP_EN
    assign w_target = w_dec_target;
`else
    assign w_target = w_unmapped ? '0 : w_dec_target;
`endif

    // rst_ni gates the combinational paths so nothing is granted while in reset.
    assign w_allowed = rst_ni && (r_cnt < C_MAX_TRANS) &&
                       ((r_cnt == '0) || (w_target == r_sel));

    always_comb begin
        w_gnt = 1'b0;
        for (int i = 0; i < NSLAVE; i++) begin
            slave_req_o[i] = '0;
        end
        if (w_allowed && master_req_i.req) begin
`ifdef NTT_INTT_EXT_ERR_RESP_EN
            if (w_target == C_UNMAP_SEL) begin
                w_gnt = 1'b1;
            end
`endif
            for (int i = 0; i < NSLAVE; i++) begin
                if (w_target == SELW'(i)) begin
                    slave_req_o[i] = master_req_i;
                    w_gnt          = slave_resp_i[i].gnt;
                end
            end
        end
    end

    always_comb begin
        w_slv_rvalid = 1'b0;
        w_slv_rdata  = '0;
        if (r_cnt != '0) begin
            for (int i = 0; i < NSLAVE; i++) begin
                if (r_sel == SELW'(i)) begin
                    w_slv_rvalid = slave_resp_i[i].rvalid;
                    w_slv_rdata  = slave_resp_i[i].rdata;
                end
            end
        end
    end

    assign w_hs  = master_req_i.req && w_gnt;
    assign w_rsp = w_slv_rvalid || r_err_rvalid;

    always_comb begin
        master_resp_o.gnt    = w_gnt;
        master_resp_o.rvalid = w_rsp;
        master_resp_o.rdata  = r_err_rvalid ? ERR_RDATA : w_slv_rdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_sel <= '0;
        end else begin
            if (w_hs && !w_rsp) begin
                r_cnt <= r_cnt + CNTW'(1);
            end else if (!w_hs && w_rsp) begin
                r_cnt <= r_cnt - CNTW'(1);
            end
            if (w_hs) begin
                r_sel <= w_target;
            end
        end
    end

`ifdef NTT_INTT_EXT_ERR_RESP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_rvalid <= 1'b0;
        end else begin
            r_err_rvalid <= w_hs && (w_target == C_UNMAP_SEL);
        end
    end
`else
    assign r_err_rvalid = 1'b0;
`endif

    assign outstanding_o = r_cnt;
    assign unmapped_o    = w_hs && w_unmapped;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < NSLAVE; i++) begin
                if (slave_resp_i[i].rvalid) begin
                    assert ((r_cnt != '0) && (r_sel == SELW'(i)))
                    else $warning("ntt_intt_ext_obi_demux: spurious rvalid on port %0d ignored", i);
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ntt_intt_ext_obi_demux.sv
// ============================================================================
// Module      : tb_ntt_intt_ext_obi_demux
// Description : Directed self-checking bench for the NTT/INTT OBI demux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntt_intt_ext_obi_demux;
    import ntt_intt_ext_xbar_pkg::*;

    localparam addr_map_rule_t [1:0] TB_RULES = {
        addr_map_rule_t'{start_addr: 32'hF020_0000, end_addr: 32'hF040_0000},
        addr_map_rule_t'{start_addr: 32'hF000_0000, end_addr: 32'hF020_0000}
    };

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    obi_req_t    mreq;
    obi_resp_t   mresp;
    obi_req_t    sreq  [2];
    obi_resp_t   sresp [2];
    logic [2:0]  outst;
    logic        unm;
    logic [1:0]  hold;
    logic [1:0]  spur;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_intt_ext_obi_demux #(
        .NSLAVE     (2),
        .MAX_TRANS  (4),
        .ADDR_RULES (TB_RULES)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .master_req_i  (mreq),
        .master_resp_o (mresp),
        .slave_req_o   (sreq),
        .slave_resp_i  (sresp),
        .outstanding_o (outst),
        .unmapped_o    (unm)
    );

    function automatic logic [31:0] rd_of(input logic [31:0] a, input int p);
        return a ^ ((p == 0) ? 32'h0000_5A00 : 32'h0000_A500);
    endfunction

    // Slave model: always grants, answers in order two cycles after the grant.
    for (genvar p = 0; p < 2; p++) begin : g_slv
        logic [31:0] q_d   [8];
        int          q_due [8];
        logic [2:0]  wp = '0;
        logic [2:0]  rp = '0;
        logic        rv;

        assign rv = (wp != rp) && (q_due[rp] <= cyc) && !hold[p];
        assign sresp[p] = {1'b1, rv | spur[p],
                           spur[p] ? 32'hDEAD_BEEF : (rv ? q_d[rp] : 32'h0)};

        always @(posedge clk) begin
            if (sreq[p].req && sresp[p].gnt) begin
                q_d[wp]   <= rd_of(sreq[p].addr, p);
                q_due[wp] <= cyc + 2;
                wp        <= wp + 3'd1;
            end
            if (rv) begin
                rp <= rp + 3'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a);
        mreq = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0};
    endtask

    task automatic idle();
        mreq = '0;
    endtask

    task automatic wait_rv(input string tag, input logic [31:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            idle();
            settle();
            seen = mresp.rvalid;
        end
        chk({tag, "_rvalid"}, {31'b0, seen}, 32'd1);
        chk(tag, mresp.rdata, exp);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hold = '0;
        spur = '0;
        rd(32'hF000_0010);

        // Reset held with a pending request.
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_s0_req", {31'b0, sreq[0].req}, 32'd0);
            chk("rst_gnt",    {31'b0, mresp.gnt},   32'd0);
            chk("rst_outst",  {29'b0, outst},       32'd0);
            chk("rst_unmap",  {31'b0, unm},         32'd0);
        end
        step();
        idle();
        rst_n = 1'b1;
        settle();
        chk("idle_gnt",   {31'b0, mresp.gnt},    32'd0);
        chk("idle_rv",    {31'b0, mresp.rvalid}, 32'd0);
        chk("idle_rdata", mresp.rdata,           32'd0);

        // Four back-to-back reads fill the tracker; the fifth waits.
        hold[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            rd(32'hF000_0010 + 32'(4 * k));
            settle();
            chk("b2b_gnt",   {31'b0, mresp.gnt}, 32'd1);
            chk("b2b_outst", {29'b0, outst},     32'(k));
        end
        step();
        rd(32'hF000_0020);
        settle();
        chk("full_gnt",   {31'b0, mresp.gnt},   32'd0);
        chk("full_outst", {29'b0, outst},       32'd4);
        chk("full_s0req", {31'b0, sreq[0].req}, 32'd0);
        step();
        hold[0] = 1'b0;
        settle();
        chk("full_rv_gnt", {31'b0, mresp.gnt},    32'd0);
        chk("full_rv",     {31'b0, mresp.rvalid}, 32'd1);
        chk("order_rd0",   mresp.rdata, rd_of(32'hF000_0010, 0));
        step();
        settle();
        chk("refill_gnt",   {31'b0, mresp.gnt},    32'd1);
        chk("refill_outst", {29'b0, outst},        32'd3);
        chk("refill_rv",    {31'b0, mresp.rvalid}, 32'd1);
        chk("order_rd1",    mresp.rdata, rd_of(32'hF000_0014, 0));
        wait_rv("order_rd2", rd_of(32'hF000_0018, 0));
        wait_rv("order_rd3", rd_of(32'hF000_001C, 0));
        wait_rv("order_rd4", rd_of(32'hF000_0020, 0));
        step();
        settle();
        chk("drain_outst", {29'b0, outst}, 32'd0);

        // Target switch waits for port0 to drain; end address maps to port1.
        step();
        rd(32'hF000_0000);
        settle();
        chk("sw_gnt0",  {31'b0, mresp.gnt},   32'd1);
        chk("sw_s0req", {31'b0, sreq[0].req}, 32'd1);
        step();
        rd(32'hF020_0000);
        settle();
        chk("sw_block_gnt",   {31'b0, mresp.gnt},   32'd0);
        chk("sw_block_s1req", {31'b0, sreq[1].req}, 32'd0);
        step();
        settle();
        chk("sw_old_rv",  {31'b0, mresp.rvalid}, 32'd1);
        chk("sw_rv_gnt",  {31'b0, mresp.gnt},    32'd0);
        chk("sw_old_rd",  mresp.rdata, rd_of(32'hF000_0000, 0));
        step();
        settle();
        chk("sw_new_gnt",   {31'b0, mresp.gnt},   32'd1);
        chk("sw_new_s1req", {31'b0, sreq[1].req}, 32'd1);
        chk("sw_new_s0req", {31'b0, sreq[0].req}, 32'd0);
        chk("sw_new_outst", {29'b0, outst},       32'd0);
        wait_rv("sw_new_rd", rd_of(32'hF020_0000, 1));

        // Handshake and response in the same cycle keep the count.
        step();
        rd(32'hF000_0040);
        settle();
        chk("sim_outst0", {29'b0, outst}, 32'd0);
        step();
        rd(32'hF000_0044);
        step();
        rd(32'hF000_0048);
        settle();
        chk("sim_outst", {29'b0, outst},        32'd2);
        chk("sim_gnt",   {31'b0, mresp.gnt},    32'd1);
        chk("sim_rv",    {31'b0, mresp.rvalid}, 32'd1);
        chk("sim_rd0",   mresp.rdata, rd_of(32'hF000_0040, 0));
        step();
        idle();
        settle();
        chk("sim_keep_outst", {29'b0, outst}, 32'd2);
        chk("sim_rd1", mresp.rdata, rd_of(32'hF000_0044, 0));
        wait_rv("sim_rd2", rd_of(32'hF000_0048, 0));

        // Unmapped access.
        step();
        rd(32'hF040_0000);
        settle();
        chk("unm_gnt",   {31'b0, mresp.gnt}, 32'd1);
        chk("unm_pulse", {31'b0, unm},       32'd1);
`ifdef NTT_INTT_EXT_ERR_RESP_EN
        chk("unm_s0req", {31'b0, sreq[0].req}, 32'd0);
        chk("unm_s1req", {31'b0, sreq[1].req}, 32'd0);
        step();
        idle();
        settle();
        chk("unm_err_rv",    {31'b0, mresp.rvalid}, 32'd1);
        chk("unm_err_rdata", mresp.rdata,           32'hBADACCE5);
        chk("unm_pulse_end", {31'b0, unm},          32'd0);
`else
        chk("unm_s0req", {31'b0, sreq[0].req}, 32'd1);
        chk("unm_s1req", {31'b0, sreq[1].req}, 32'd0);
        wait_rv("unm_rd", rd_of(32'hF040_0000, 0));
`endif

        // Spurious rvalid while idle is ignored.
        step();
        idle();
        spur[1] = 1'b1;
        settle();
        chk("spur_rv",    {31'b0, mresp.rvalid}, 32'd0);
        chk("spur_rdata", mresp.rdata,           32'd0);
        chk("spur_outst", {29'b0, outst},        32'd0);
        step();
        spur = '0;
        settle();
        chk("spur_after_outst", {29'b0, outst}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
